// File: rtl/uart_cipher_block_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cipher_block_bridge_if
// Brief    : Byte-stream and block handshake bundle for the cipher bridge.
// Revision : 1.0
// ============================================================================
interface uart_cipher_block_bridge_if #(
    parameter int BLOCK_BYTES = 16
);
    logic [7:0]               rx_byte;
    logic                     rx_byte_valid;
    logic [8*BLOCK_BYTES-1:0] core_in_data;
    logic                     core_in_valid;
    logic                     core_in_ready;
    logic [8*BLOCK_BYTES-1:0] core_out_data;
    logic                     core_out_valid;
    logic                     core_out_ready;
    logic [7:0]               tx_byte;
    logic                     tx_byte_valid;
    logic                     tx_byte_ready;

    // Bridge side
    modport master (
        input  rx_byte, rx_byte_valid,
        output core_in_data, core_in_valid,
        input  core_in_ready,
        input  core_out_data, core_out_valid,
        output core_out_ready,
        output tx_byte, tx_byte_valid,
        input  tx_byte_ready
    );

    // UART and block-core side
    modport slave (
        output rx_byte, rx_byte_valid,
        input  core_in_data, core_in_valid,
        output core_in_ready,
        output core_out_data, core_out_valid,
        input  core_out_ready,
        input  tx_byte, tx_byte_valid,
        output tx_byte_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_cipher_block_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_cipher_block_bridge
// Brief    : Packs rx bytes into blocks for the core; buffers core results and
//            serialises them back onto the tx byte path.
// Revision : 1.0
// ============================================================================
module uart_cipher_block_bridge #(
    parameter int BLOCK_BYTES = 16,
    parameter int OUT_DEPTH   = 2,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int TIMEOUT_CYC = 0
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    uart_cipher_block_bridge_if.master bus,
    input  wire logic                  err_clr,
    output logic                       overrun_err,
    output logic                       timeout_err
);
    localparam int c_W     = 8 * BLOCK_BYTES;
    localparam int c_CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam int c_AW    = $clog2(OUT_DEPTH);
    localparam int c_TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BLOCK_BYTES - 1);

    // ---------------- rx assembly and holding register ----------------
    logic [c_CNT_W-1:0] r_byte_cnt;
    logic [c_W-1:0]     r_asm;
    logic [c_W-1:0]     w_asm_next;
    logic [c_W-1:0]     r_hold_data;
    logic               r_hold_valid;
    logic               w_complete;
    logic               w_hold_xfer;
    logic               w_overrun;
    logic               w_timeout;

    always_comb begin
        w_asm_next = r_asm;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (r_byte_cnt == c_CNT_W'(MSB_FIRST ? (BLOCK_BYTES - 1 - i) : i))
                w_asm_next[8*i +: 8] = bus.rx_byte;
        end
    end

    assign w_complete  = bus.rx_byte_valid && (r_byte_cnt == c_LAST);
    assign w_hold_xfer = r_hold_valid && bus.core_in_ready;
    // A completion that coincides with the holding transfer simply reloads it.
    assign w_overrun   = w_complete && r_hold_valid && !bus.core_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt   <= '0;
            r_asm        <= '0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else begin
            if (bus.rx_byte_valid) begin
                r_asm      <= w_asm_next;
                r_byte_cnt <= w_complete ? '0 : r_byte_cnt + 1'b1;
            end else if (w_timeout) begin
                r_byte_cnt <= '0;
            end
            if (w_complete && !w_overrun) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= w_asm_next;
            end else if (w_hold_xfer) begin
                r_hold_valid <= 1'b0;
                r_hold_data  <= '0;
            end
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);
            logic [c_TO_W-1:0] r_idle;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_idle <= '0;
                else if (bus.rx_byte_valid || (r_byte_cnt == '0) || (r_idle == c_TO_LAST))
                    r_idle <= '0;
                else
                    r_idle <= r_idle + 1'b1;
            end

            assign w_timeout = !bus.rx_byte_valid && (r_byte_cnt != '0) && (r_idle == c_TO_LAST);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (w_overrun)    overrun_err <= 1'b1;
            else if (err_clr) overrun_err <= 1'b0;
            if (w_timeout)    timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

    assign bus.core_in_valid = r_hold_valid;
    assign bus.core_in_data  = r_hold_data;

    // ---------------- result FIFO ----------------
    logic [c_W-1:0] r_mem [OUT_DEPTH];
    logic [c_AW:0]  r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic           r_out_ready;
    logic           w_push, w_pop, w_empty;
    logic [c_W-1:0] w_head;

    function automatic logic is_full(input logic [c_AW:0] wp, input logic [c_AW:0] rp);
        return (wp[c_AW] != rp[c_AW]) && (wp[c_AW-1:0] == rp[c_AW-1:0]);
    endfunction

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_push       = bus.core_out_valid && r_out_ready;
    assign w_wr_ptr_nxt = r_wr_ptr + (c_AW+1)'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + (c_AW+1)'(w_pop);
    assign w_head       = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= bus.core_out_data;
    end

    // Ready is registered from the next-state occupancy so it reads 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_ready <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_out_ready <= !is_full(w_wr_ptr_nxt, w_rd_ptr_nxt);
        end
    end

    assign bus.core_out_ready = r_out_ready;

    // ---------------- tx serialiser ----------------
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} tx_state_t;

    tx_state_t          r_state;
    logic [c_W-1:0]     r_shift;
    logic [c_CNT_W-1:0] r_slot;
    logic               r_tx_valid;
    logic               w_tx_hs, w_last_hs;

    assign w_tx_hs   = r_tx_valid && bus.tx_byte_ready;
    assign w_last_hs = w_tx_hs && (r_slot == c_LAST);
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || w_last_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_slot     <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_head;
                        r_slot     <= '0;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_last_hs) begin
                        r_slot <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end else if (w_tx_hs) begin
                        r_slot  <= r_slot + 1'b1;
                        r_shift <= MSB_FIRST ? (r_shift << 8) : (r_shift >> 8);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_byte_valid = r_tx_valid;
    assign bus.tx_byte       = MSB_FIRST ? r_shift[c_W-1 -: 8] : r_shift[7:0];
endmodule
`default_nettype wire
